// File: rtl/tff_div_pkg.sv
// tff_div_pkg: shared types and defaults for the toggle divider
package tff_div_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
    localparam int W_DEF = 8;
    localparam int DIV_RST_DEF = 0;
endpackage

// File: rtl/tff_sync_cell.sv
// tff_sync_cell: 1-bit T flip-flop with synchronous clear (CD) over preset (SD)
module tff_sync_cell (
    input  logic CP,
    input  logic CD,
    input  logic SD,
    input  logic T,
    output logic Q,
    output logic QN
);
    always_ff @(posedge CP)
        if (CD) Q <= 1'b0;
        else if (SD) Q <= 1'b1;
        else if (T) Q <= ~Q;
    assign QN = ~Q;
endmodule

// File: rtl/tff_toggle_divider.sv
// tff_toggle_divider: programmable divider toggling a TFF once per DIV+1 enabled cycles
module tff_toggle_divider
    import tff_div_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int DIV_RST = DIV_RST_DEF
) (
    input  logic         CP,
    input  logic         CD,
    input  logic         EN,
    input  logic         SD,
    input  logic         LOAD_VALID,
    output logic         LOAD_READY,
    input  logic [W-1:0] DIV,
    output logic         TGL,
    output logic         Q,
    output logic         QN,
    output logic [W-1:0] CNT
);
    state_t state, state_n;
    logic [W-1:0] cnt, div_r, pend;
    logic term, accept;
    assign term = (state != IDLE) && EN && (cnt == div_r);
    assign accept = LOAD_VALID && LOAD_READY;
    always_ff @(posedge CP)
        if (CD) state <= IDLE;
        else if (!SD) state <= state_n;
    always_comb begin
        state_n = state;
        if (!EN) state_n = IDLE;
        else if (state == IDLE) state_n = RUN;
        else if (state == RUN && accept) state_n = PEND;
        else if (state == PEND && term) state_n = RUN;
    end
    always_comb LOAD_READY = (state != PEND);
    // A new divisor taking effect off a terminal edge always restarts the count at 0
    always_ff @(posedge CP)
        if (CD) begin
            cnt <= '0;
            div_r <= W'(DIV_RST);
            pend <= '0;
            TGL <= 1'b0;
        end else if (SD) begin
            cnt <= '0;
            TGL <= 1'b0;
        end else begin
            TGL <= term;
            if (state == IDLE || !EN) begin
                if (state == PEND) begin
                    div_r <= pend;
                    cnt <= '0;
                end else if (accept) begin
                    div_r <= DIV;
                    cnt <= '0;
                end
            end else begin
                cnt <= term ? '0 : cnt + 1'b1;
                if (state == RUN && accept) pend <= DIV;
                if (state == PEND && term) div_r <= pend;
            end
        end
    tff_sync_cell u_cell (
        .CP(CP),
        .CD(CD),
        .SD(SD),
        .T (term),
        .Q (Q),
        .QN(QN)
    );
    assign CNT = cnt;
endmodule

// File: tb/tb_tff_toggle_divider.sv
// tb_tff_toggle_divider: random and directed checks against a period-counting reference model
module tb_tff_toggle_divider;
    logic CP = 1'b0;
    logic CD = 1'b1, EN = 1'b0, SD = 1'b0, LOAD_VALID = 1'b0;
    logic [7:0] DIV = '0;
    logic LOAD_READY, TGL, Q, QN;
    logic [7:0] CNT;
    int n_chk = 0, n_fail = 0;

    tff_toggle_divider #(.W(8), .DIV_RST(0)) dut (
        .CP(CP), .CD(CD), .EN(EN), .SD(SD),
        .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY), .DIV(DIV),
        .TGL(TGL), .Q(Q), .QN(QN), .CNT(CNT)
    );

    always #5 CP = ~CP;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a divisor in force, an optional staged divisor, a phase within the period
    int m_cnt = 0, m_div = 0, m_pend = 0;
    bit m_has = 0, m_act = 0, m_q = 0, m_tgl = 0;

    task automatic model_step();
        bit acc;
        if (CD) begin
            m_cnt = 0; m_div = 0; m_pend = 0;
            m_has = 0; m_act = 0; m_q = 0; m_tgl = 0;
        end else if (SD) begin
            m_q = 1; m_cnt = 0; m_tgl = 0;
        end else begin
            acc = LOAD_VALID && !m_has;
            if (m_act && EN) begin
                m_tgl = (m_cnt == m_div);
                if (m_tgl) begin
                    m_q = !m_q;
                    m_cnt = 0;
                    if (m_has) begin
                        m_div = m_pend;
                        m_has = 0;
                    end
                end else m_cnt = m_cnt + 1;
                if (acc) begin
                    m_pend = int'(DIV);
                    m_has = 1;
                end
            end else begin
                m_tgl = 0;
                if (m_has) begin
                    m_div = m_pend;
                    m_has = 0;
                    m_cnt = 0;
                end else if (acc) begin
                    m_div = int'(DIV);
                    m_cnt = 0;
                end
            end
            m_act = EN;
        end
    endtask

    initial begin
        @(posedge CP);
        forever begin
            @(negedge CP);
            chk("model_tgl", 32'(TGL), 32'(m_tgl));
            chk("model_q", 32'(Q), 32'(m_q));
            chk("model_qn", 32'(QN), 32'(!m_q));
            chk("model_cnt", 32'(CNT), 32'(m_cnt));
            chk("model_ready", 32'(LOAD_READY), 32'(!m_has));
            model_step();
        end
    end

    task automatic cyc(input logic cd, input logic sd, input logic en, input logic lv, input logic [7:0] dv);
        CD = cd; SD = sd; EN = en; LOAD_VALID = lv; DIV = dv;
        @(posedge CP);
        #1;
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("rst_q", 32'(Q), 0);
        chk("rst_qn", 32'(QN), 1);
        chk("rst_tgl", 32'(TGL), 0);
        chk("rst_cnt", 32'(CNT), 0);
        chk("rst_ready", 32'(LOAD_READY), 1);
        cyc(0, 0, 0, 1, 3);
        repeat (4) cyc(0, 0, 1, 0, 0);
        chk("div3_cnt3", 32'(CNT), 3);
        chk("div3_no_tgl", 32'(TGL), 0);
        cyc(0, 0, 1, 0, 0);
        chk("div3_tgl1", 32'(TGL), 1);
        chk("div3_q1", 32'(Q), 1);
        repeat (3) cyc(0, 0, 1, 0, 0);
        chk("div3_mid", 32'(TGL), 0);
        cyc(0, 0, 1, 0, 0);
        chk("div3_tgl2", 32'(TGL), 1);
        chk("div3_q0", 32'(Q), 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 1);
        chk("pend_ready0", 32'(LOAD_READY), 0);
        cyc(0, 0, 1, 1, 7);
        chk("pend_cnt3", 32'(CNT), 3);
        cyc(0, 0, 1, 0, 0);
        chk("pend_term_tgl", 32'(TGL), 1);
        chk("pend_ready1", 32'(LOAD_READY), 1);
        cyc(0, 0, 1, 0, 0);
        chk("div1_mid", 32'(TGL), 0);
        cyc(0, 0, 1, 0, 0);
        chk("div1_tgl", 32'(TGL), 1);
        chk("div1_q", 32'(Q), 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("div0_q1", 32'(Q), 1);
        chk("div0_tgl", 32'(TGL), 1);
        cyc(0, 0, 1, 0, 0);
        chk("div0_q0", 32'(Q), 0);
        repeat (3) begin
            cyc(0, 0, 0, 0, 0);
            chk("hold_q", 32'(Q), 0);
            chk("hold_cnt", 32'(CNT), 0);
            chk("hold_tgl", 32'(TGL), 0);
        end
        cyc(0, 0, 0, 1, 5);
        repeat (3) cyc(0, 0, 1, 0, 0);
        chk("sd_pre_cnt", 32'(CNT), 2);
        cyc(0, 1, 1, 0, 0);
        chk("sd_q", 32'(Q), 1);
        chk("sd_cnt", 32'(CNT), 0);
        cyc(1, 1, 0, 0, 0);
        chk("cd_over_sd_q", 32'(Q), 0);
        cyc(0, 0, 0, 1, 4);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 7);
        chk("cdp_ready0", 32'(LOAD_READY), 0);
        cyc(1, 0, 1, 0, 0);
        chk("cdp_ready1", 32'(LOAD_READY), 1);
        chk("cdp_cnt", 32'(CNT), 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("cdp_divrst_tgl", 32'(TGL), 1);
        cyc(0, 0, 0, 1, 8'hFF);
        cyc(0, 0, 1, 0, 0);
        repeat (255) cyc(0, 0, 1, 0, 0);
        chk("wrap_cnt255", 32'(CNT), 255);
        chk("wrap_pre_tgl", 32'(TGL), 0);
        cyc(0, 0, 1, 0, 0);
        chk("wrap_tgl", 32'(TGL), 1);
        chk("wrap_cnt0", 32'(CNT), 0);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(63) == 0, $urandom_range(31) == 0, $urandom_range(4) != 0,
                $urandom_range(7) == 0, ($urandom_range(15) == 0) ? 8'hFF : 8'($urandom_range(6)));
        @(negedge CP);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
